// File: rtl/arith_range_update_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arith_range_update_pkg
//  Brief    : Shared constants and FSM encoding for the range-update stage.
//  Revision : 1.0
// ============================================================================
package arith_range_update_pkg;

    localparam int EC_MIN_PROB = 4;
    localparam int RNG_INIT    = 32768;
    localparam int PROB_SHIFT  = 6;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/arith_range_update_range_lzc.sv
`default_nettype none
// ============================================================================
//  Module   : range_lzc
//  Brief    : Combinational leading-zero count giving the normalization shift.
//  Revision : 1.0
// ============================================================================
module range_lzc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [CNT_W-1:0] o_count
);
    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        o_count = CNT_W'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_value[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/lut_uv_modules.sv
`default_nettype none
// ============================================================================
//  Module   : lut_u_module / lut_v_module
//  Brief    : EC_MIN_PROB correction LUTs addressed by {N, s}.
//  Revision : 1.0
// ============================================================================
module lut_u_module #(
    parameter int DATA_W = 16
) (
    input  logic [7:0]        i_addr,
    output logic [DATA_W-1:0] o_data
);
    logic [3:0] w_n;
    logic [3:0] w_s;
    logic [4:0] w_cnt;

    assign w_n    = i_addr[7:4];
    assign w_s    = i_addr[3:0];
    assign w_cnt  = {1'b0, w_n} - {1'b0, w_s} + 5'd1;
    // Addresses with s > N are not real symbols and read as zero.
    assign o_data = (w_s <= w_n) ? DATA_W'({w_cnt, 2'b00}) : '0;
endmodule

module lut_v_module #(
    parameter int DATA_W = 16
) (
    input  logic [7:0]        i_addr,
    output logic [DATA_W-1:0] o_data
);
    logic [3:0] w_n;
    logic [3:0] w_s;
    logic [4:0] w_cnt;

    assign w_n    = i_addr[7:4];
    assign w_s    = i_addr[3:0];
    assign w_cnt  = {1'b0, w_n} - {1'b0, w_s};
    assign o_data = (w_s <= w_n) ? DATA_W'({w_cnt, 2'b00}) : '0;
endmodule
`default_nettype wire

// File: rtl/arith_range_update.sv
`default_nettype none
// ============================================================================
//  Module   : arith_range_update
//  Brief    : Range update and renormalization for the AV1 entropy encoder.
//  Revision : 1.0
// ============================================================================
module arith_range_update
    import arith_range_update_pkg::*;
#(
    parameter int RANGE_WIDTH = 16,
    parameter int D_WIDTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   bool_flag,
    input  logic [RANGE_WIDTH-1:0] fl,
    input  logic [RANGE_WIDTH-1:0] fh,
    input  logic [3:0]             symbol,
    input  logic [3:0]             nsyms_m1,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RANGE_WIDTH-1:0] low_add,
    output logic [D_WIDTH-1:0]     shift,
    output logic [RANGE_WIDTH-1:0] range_out,
    output logic                   out_last
);
    localparam int c_q_w = RANGE_WIDTH - PROB_SHIFT;
    localparam int c_p_w = c_q_w + 8;

    logic [STATE_W-1:0]     r_state;
    logic [STATE_W-1:0]     w_state_nxt;
    logic [RANGE_WIDTH-1:0] r_rng;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [RANGE_WIDTH-1:0] r_low_add;
    logic [D_WIDTH-1:0]     r_shift;
    logic [RANGE_WIDTH-1:0] r_range;

    logic                   w_can_load;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_load_flush;
    logic                   w_flush_done;

    logic [7:0]             w_r8;
    logic [c_p_w-1:0]       w_prod_l;
    logic [c_p_w-1:0]       w_prod_h;
    logic [RANGE_WIDTH-1:0] w_u_min;
    logic [RANGE_WIDTH-1:0] w_v_min;
    logic [RANGE_WIDTH-1:0] w_u;
    logic [RANGE_WIDTH-1:0] w_v;
    logic [RANGE_WIDTH-1:0] w_low_add;
    logic [RANGE_WIDTH-1:0] w_rnew;
    logic [RANGE_WIDTH-1:0] w_rng_norm;
    logic [D_WIDTH-1:0]     w_d;

    lut_u_module #(.DATA_W(RANGE_WIDTH)) u_lut_u (
        .i_addr ({nsyms_m1, symbol}),
        .o_data (w_u_min)
    );

    lut_v_module #(.DATA_W(RANGE_WIDTH)) u_lut_v (
        .i_addr ({nsyms_m1, symbol}),
        .o_data (w_v_min)
    );

    // Products keep 18 bits so the halving happens before truncation to 16.
    assign w_r8     = r_rng[RANGE_WIDTH-1 -: 8];
    assign w_prod_l = {{(c_p_w - 8){1'b0}}, w_r8} * {8'd0, fl[RANGE_WIDTH-1:PROB_SHIFT]};
    assign w_prod_h = {{(c_p_w - 8){1'b0}}, w_r8} * {8'd0, fh[RANGE_WIDTH-1:PROB_SHIFT]};
    assign w_u      = w_prod_l[RANGE_WIDTH:1] + w_u_min;
    assign w_v      = w_prod_h[RANGE_WIDTH:1] + (bool_flag ? RANGE_WIDTH'(EC_MIN_PROB) : w_v_min);

    always_comb begin
        w_low_add = '0;
        w_rnew    = '0;
        if (bool_flag) begin
            if (symbol[0]) begin
                w_low_add = r_rng - w_v;
                w_rnew    = w_v;
            end else begin
                w_rnew    = r_rng - w_v;
            end
        end else if (fl[RANGE_WIDTH-1]) begin
            w_rnew    = r_rng - w_v;
        end else begin
            w_low_add = r_rng - w_u;
            w_rnew    = w_u - w_v;
        end
    end

    range_lzc #(.WIDTH(RANGE_WIDTH), .CNT_W(D_WIDTH)) u_lzc (
        .i_value (w_rnew),
        .o_count (w_d)
    );

    assign w_rng_norm = w_rnew << w_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a symbol on the same cycle masks flush
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)              w_state_nxt = ST_RUN;
            ST_RUN:   if (!in_valid && flush)    w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_done)          w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/handshake decode; the flush record loads once the output slot frees
    always_comb begin
        w_can_load   = !r_out_valid || out_ready;
        w_in_ready   = (r_state != ST_FLUSH) && w_can_load;
        w_accept     = in_valid && w_in_ready;
        w_load_flush = (r_state == ST_FLUSH) && w_can_load && !(r_out_valid && r_out_last);
        w_flush_done = (r_state == ST_FLUSH) && r_out_valid && r_out_last && out_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rng <= RANGE_WIDTH'(RNG_INIT);
        end else if (w_accept) begin
            r_rng <= w_rng_norm;
        end else if (w_flush_done) begin
            r_rng <= RANGE_WIDTH'(RNG_INIT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_low_add   <= '0;
            r_shift     <= '0;
            r_range     <= RANGE_WIDTH'(RNG_INIT);
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_low_add   <= w_low_add;
            r_shift     <= w_d;
            r_range     <= w_rng_norm;
        end else if (w_load_flush) begin
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_low_add   <= '0;
            r_shift     <= '0;
            r_range     <= r_rng;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign low_add   = r_low_add;
    assign shift     = r_shift;
    assign range_out = r_range;

endmodule
`default_nettype wire
